// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and drives datapath selects.
// Latency: outputs are combinational from the current state; state advances one step per clock.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low; mem_ready is ignored elsewhere.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   op, funct3, funct7b5 instruction fields; zero = ALU zero flag; mem_ready = memory handshake
//   pc_write, adr_src, mem_write, ir_write, reg_write   datapath enables / address select
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control   datapath mux / ALU selects
//   illegal_op          one-cycle pulse from DECODE on an unsupported opcode
//   state               current state encoding for debug
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e     state_q, state_d;
  logic [2:0] alu_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign state = state_q;

  // funct3=000 is sub only for R-type with funct7b5 set; I-type addi
  // reuses instr[30] as an immediate bit, so op[5] qualifies it.
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 2'b10;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BEQ:            state_d = S_BEQ;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = op[5] ? 2'b01 : 2'b00;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        // Held high through the stall; memory commits on the mem_ready cycle.
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_dec;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_src   = 2'b11;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // The state register resets asynchronously, but FETCH still decodes
    // mem_ready, so the enables must be squashed directly while in reset.
    if (!rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboarded directed bench for multicycle_controller.
// Each stimulus cycle queues its expected output vector; a negedge monitor pops and compares.
// No backpressure: one expected vector per clock.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal_op(illegal_op),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t e(input logic [3:0] st, input logic pcw, input logic adr,
                             input logic mw, input logic irw, input logic rw,
                             input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                             input logic [1:0] imm, input logic [2:0] alu, input logic ill);
    vec_t v;
    v = {st, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    return v;
  endfunction

  // Hand-written expected vectors for each state.
  function automatic vec_t v_fetch(input logic mr);
    return e(4'd0, mr, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_fetch_rst();
    return e(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_decode(input logic ill);
    return e(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, ill);
  endfunction
  function automatic vec_t v_memadr(input logic [1:0] imm);
    return e(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_memread();
    return e(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_memwb();
    return e(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_memwrite();
    return e(4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_execr(input logic [2:0] alu);
    return e(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 1'b0);
  endfunction
  function automatic vec_t v_aluwb();
    return e(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_execi(input logic [2:0] alu);
    return e(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 1'b0);
  endfunction
  function automatic vec_t v_jal();
    return e(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0);
  endfunction
  function automatic vec_t v_beq(input logic z);
    return e(4'd10, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0);
  endfunction

  // Called at posedge+1: apply inputs for this cycle, queue what the DUT must show.
  task automatic step(input string tag, input logic mr, input vec_t ex);
    mem_ready = mr;
    exp_q.push_back(ex);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic is_r, input logic [2:0] alu);
    set_instr(o, f3, f7);
    step({tag, "_fetch"}, 1'b1, v_fetch(1'b1));
    step({tag, "_decode"}, 1'b0, v_decode(1'b0));
    if (is_r) step({tag, "_execr"}, 1'b0, v_execr(alu));
    else      step({tag, "_execi"}, 1'b0, v_execi(alu));
    step({tag, "_aluwb"}, 1'b1, v_aluwb());
  endtask

  // Monitor: compares every sampled cycle against the queued expectation.
  initial begin
    vec_t  ex;
    vec_t  act;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        ex  = exp_q.pop_front();
        t   = tag_q.pop_front();
        act = {state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, illegal_op};
        n_checks++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                   t, act.st, act, ex.st, ex);
        end
      end
    end
  end

  initial begin
    int waited;
    rst       = 1'b0;
    op        = 7'b0;
    funct3    = 3'b0;
    funct7b5  = 1'b0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset with mem_ready high: FETCH selects but no enables.
    step("rst_hold0", 1'b1, v_fetch_rst());
    step("rst_hold1", 1'b1, v_fetch_rst());
    rst = 1'b1;
    step("fetch_stall", 1'b0, v_fetch(1'b0));

    // R-type add / sub / or, I-type slti and addi with instr[30] set.
    run_alu("add",  7'b0110011, 3'b000, 1'b0, 1'b1, 3'b000);
    run_alu("sub",  7'b0110011, 3'b000, 1'b1, 1'b1, 3'b001);
    run_alu("or",   7'b0110011, 3'b110, 1'b0, 1'b1, 3'b011);
    run_alu("and",  7'b0110011, 3'b111, 1'b0, 1'b1, 3'b010);
    run_alu("slti", 7'b0010011, 3'b010, 1'b0, 1'b0, 3'b101);
    run_alu("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000);
    run_alu("xor",  7'b0110011, 3'b100, 1'b0, 1'b1, 3'b000);

    // lw with three stall cycles in MEMREAD.
    set_instr(7'b0000011, 3'b010, 1'b0);
    step("lw_fetch", 1'b1, v_fetch(1'b1));
    step("lw_decode", 1'b0, v_decode(1'b0));
    step("lw_memadr", 1'b0, v_memadr(2'b00));
    for (int i = 0; i < 3; i++) step("lw_memread_stall", 1'b0, v_memread());
    step("lw_memread_done", 1'b1, v_memread());
    step("lw_memwb", 1'b0, v_memwb());

    // sw with no stall.
    set_instr(7'b0100011, 3'b010, 1'b0);
    step("sw_fetch", 1'b1, v_fetch(1'b1));
    step("sw_decode", 1'b1, v_decode(1'b0));
    step("sw_memadr", 1'b1, v_memadr(2'b01));
    step("sw_memwrite", 1'b1, v_memwrite());

    // beq taken, then not taken.
    set_instr(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    step("beq1_fetch", 1'b1, v_fetch(1'b1));
    step("beq1_decode", 1'b1, v_decode(1'b0));
    step("beq1_taken", 1'b1, v_beq(1'b1));
    zero = 1'b0;
    step("beq0_fetch", 1'b1, v_fetch(1'b1));
    step("beq0_decode", 1'b1, v_decode(1'b0));
    step("beq0_nottaken", 1'b1, v_beq(1'b0));

    // jal.
    set_instr(7'b1101111, 3'b000, 1'b0);
    step("jal_fetch", 1'b1, v_fetch(1'b1));
    step("jal_decode", 1'b1, v_decode(1'b0));
    step("jal_exec", 1'b1, v_jal());
    step("jal_aluwb", 1'b1, v_aluwb());

    // Unsupported opcode.
    set_instr(7'b1111111, 3'b000, 1'b0);
    step("ill_fetch", 1'b1, v_fetch(1'b1));
    step("ill_decode", 1'b1, v_decode(1'b1));
    step("ill_back_fetch", 1'b0, v_fetch(1'b0));

    // Reset asserted mid-MEMWRITE stall.
    set_instr(7'b0100011, 3'b010, 1'b0);
    step("swr_fetch", 1'b1, v_fetch(1'b1));
    step("swr_decode", 1'b0, v_decode(1'b0));
    step("swr_memadr", 1'b0, v_memadr(2'b01));
    step("swr_memwrite_stall", 1'b0, v_memwrite());
    rst = 1'b0;
    step("swr_rst_now", 1'b0, v_fetch_rst());
    step("swr_rst_hold", 1'b1, v_fetch_rst());
    rst = 1'b1;
    step("post_rst_fetch", 1'b1, v_fetch(1'b1));
    set_instr(7'b0110011, 3'b000, 1'b0);
    step("post_rst_decode", 1'b1, v_decode(1'b0));
    step("post_rst_execr", 1'b1, v_execr(3'b000));

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
